// File: rtl/int_req_ctrl.sv
// Prioritised interrupt request controller: synchronises device requests, holds pending/overflow
// flags and runs an ASSERT/GAP/SERVICE handshake with the CPU, re-triggering INT on timeout.
module int_req_ctrl #(
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] mask,
    input  logic             INTA,
    input  logic             eret,
    input  logic             ovf_clr,
    output logic             INT,
    output logic [2:0]       src_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overflow,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP, S_SERVICE} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;
    logic [N_SRC-1:0] r_sync_d;
    logic [1:0]       r_arm;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_ovf;
    logic [2:0]       r_src;
    logic [7:0]       r_cnt;
    logic             r_int;
    logic             r_busy;

    logic [N_SRC-1:0] w_event;
    logic [N_SRC-1:0] w_elig;
    logic [N_SRC-1:0] w_cur_sel;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pend_nx;
    logic [N_SRC-1:0] w_ovf_set;
    logic [2:0]       w_win;
    logic [2:0]       w_src_nx;
    logic [7:0]       w_cnt_nx;
    logic             w_any;
    logic             w_cur_masked;
    logic             w_ack;

    // r_sync_d remembers the previous synchronized level for edge detection. r_arm keeps edges
    // suppressed until that history is valid, so a pin already high at reset release is not an event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
            r_arm    <= 2'd0;
        end else begin
            r_sync1  <= irq_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    assign w_event      = (r_arm == 2'd3) ? (r_sync2 & ~r_sync_d) : '0;
    assign w_elig       = r_pend & mask;
    assign w_any        = |w_elig;
    assign w_cur_masked = |(mask & w_cur_sel);

    always_comb begin
        w_win     = 3'd0;
        w_cur_sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = 3'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            w_cur_sel[i] = (r_src == 3'(i));
        end
    end

    // Withdrawal on a dropped mask takes precedence over an acknowledge in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_src_nx   = r_src;
        w_cnt_nx   = r_cnt;
        w_ack      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nx = S_ASSERT;
                    w_src_nx   = w_win;
                    w_cnt_nx   = 8'd0;
                end
            end
            S_ASSERT: begin
                if (!w_cur_masked) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 8'd0;
                end else if (INTA) begin
                    w_ack      = 1'b1;
                    w_state_nx = S_SERVICE;
                    w_cnt_nx   = 8'd0;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_GAP: begin
                w_cnt_nx = 8'd0;
                if (!w_cur_masked) begin
                    w_state_nx = S_IDLE;
                end else if (INTA) begin
                    w_ack      = 1'b1;
                    w_state_nx = S_SERVICE;
                end else begin
                    w_state_nx = S_ASSERT;
                end
            end
            S_SERVICE: begin
                if (eret) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // A new event always survives a same-cycle clear; it only overflows if it was already pending.
    assign w_clr     = w_ack ? w_cur_sel : '0;
    assign w_pend_nx = (r_pend & ~w_clr) | w_event;
    assign w_ovf_set = w_event & r_pend & ~w_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_src   <= 3'd0;
            r_cnt   <= 8'd0;
            r_pend  <= '0;
            r_ovf   <= '0;
            r_int   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_src   <= w_src_nx;
            r_cnt   <= w_cnt_nx;
            r_pend  <= w_pend_nx;
            r_ovf   <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
            r_int   <= (w_state_nx == S_ASSERT);
            r_busy  <= (w_state_nx != S_IDLE);
        end
    end

    assign INT      = r_int;
    assign src_id   = r_src;
    assign pending  = r_pend;
    assign overflow = r_ovf;
    assign busy     = r_busy;

endmodule

// File: tb/tb_int_req_ctrl.sv
// Scoreboard bench for int_req_ctrl: directed stimulus queues expected output snapshots and
// expected request source ids; a negedge monitor pops and compares them.
module tb_int_req_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic       INTA;
    logic       eret;
    logic       ovf_clr;
    logic       INT;
    logic [2:0] src_id;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       busy;

    int_req_ctrl #(.N_SRC(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .INTA(INTA), .eret(eret),
        .ovf_clr(ovf_clr), .INT(INT), .src_id(src_id), .pending(pending),
        .overflow(overflow), .busy(busy)
    );

    typedef struct packed {
        int         cyc;
        logic       iv;
        logic [2:0] s;
        logic [3:0] p;
        logic [3:0] o;
        logic       b;
    } exp_t;

    exp_t       exp_q[$];
    string      nm_q[$];
    logic [2:0] irq_q[$];
    int         cyc = 0;
    int         vectors = 0;
    int         fails = 0;
    exp_t       e;
    string      nm;
    logic       int_prev = 1'b0;
    logic [2:0] exp_src;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: snapshot checks at their scheduled cycle, plus every rising INT edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            vectors++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL %s: check scheduled for cycle %0d not reached in time (now %0d)", nm, e.cyc, cyc);
            end else if ({INT, src_id, pending, overflow, busy} !== {e.iv, e.s, e.p, e.o, e.b}) begin
                fails++;
                $display("FAIL %s: got INT=%0b src_id=%0d pending=%b overflow=%b busy=%0b, want INT=%0b src_id=%0d pending=%b overflow=%b busy=%0b",
                         nm, INT, src_id, pending, overflow, busy, e.iv, e.s, e.p, e.o, e.b);
            end
        end
        if (rst && INT === 1'b1 && int_prev === 1'b0) begin
            vectors++;
            if (irq_q.size() == 0) begin
                fails++;
                $display("FAIL int_rise: unexpected INT rising edge with src_id=%0d at cycle %0d", src_id, cyc);
            end else begin
                exp_src = irq_q.pop_front();
                if (src_id !== exp_src) begin
                    fails++;
                    $display("FAIL int_rise: src_id=%0d, want %0d at cycle %0d", src_id, exp_src, cyc);
                end
            end
        end
        int_prev = INT;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int d, input string name, input logic iv, input logic [2:0] s,
                             input logic [3:0] p, input logic [3:0] o, input logic b);
        exp_t x;
        x.cyc = cyc + d;
        x.iv  = iv;
        x.s   = s;
        x.p   = p;
        x.o   = o;
        x.b   = b;
        exp_q.push_back(x);
        nm_q.push_back(name);
    endtask

    initial begin
        rst = 1'b0; irq_in = 4'h0; mask = 4'hF; INTA = 1'b0; eret = 1'b0; ovf_clr = 1'b0;
        tick(1);
        expect_at(0, "reset", 0, 0, 4'h0, 4'h0, 0);
        tick(1);
        rst = 1'b1;
        tick(4);

        // Single event on source 2
        irq_in = 4'b0100; irq_q.push_back(3'd2);
        expect_at(3, "A_pend", 0, 0, 4'b0100, 4'h0, 0);
        expect_at(4, "A_int",  1, 2, 4'b0100, 4'h0, 1);
        tick(4);
        INTA = 1'b1; expect_at(1, "A_ack", 0, 2, 4'h0, 4'h0, 1);
        tick(1);
        INTA = 1'b0; eret = 1'b1; expect_at(1, "A_eret", 0, 2, 4'h0, 4'h0, 0);
        tick(1);
        eret = 1'b0; irq_in = 4'h0;
        tick(3);

        // Priority: sources 3 and 1 together
        irq_in = 4'b1010; irq_q.push_back(3'd1);
        expect_at(3, "B_pend", 0, 2, 4'b1010, 4'h0, 0);
        expect_at(4, "B_int",  1, 1, 4'b1010, 4'h0, 1);
        tick(4);
        eret = 1'b1; expect_at(1, "B_eret_ign", 1, 1, 4'b1010, 4'h0, 1);
        tick(1);
        eret = 1'b0; INTA = 1'b1; expect_at(1, "B_ack", 0, 1, 4'b1000, 4'h0, 1);
        tick(1);
        INTA = 1'b1; eret = 1'b1; irq_q.push_back(3'd3);
        expect_at(1, "B_both", 0, 1, 4'b1000, 4'h0, 0);
        expect_at(2, "B_next", 1, 3, 4'b1000, 4'h0, 1);
        tick(1);
        INTA = 1'b0; eret = 1'b0;
        tick(1);
        INTA = 1'b1; expect_at(1, "B_ack3", 0, 3, 4'h0, 4'h0, 1);
        tick(1);
        INTA = 1'b0; eret = 1'b1; expect_at(1, "B_done", 0, 3, 4'h0, 4'h0, 0);
        tick(1);
        eret = 1'b0; irq_in = 4'h0;
        tick(3);

        // Timeout and re-trigger
        irq_in = 4'b0001; irq_q.push_back(3'd0); irq_q.push_back(3'd0);
        expect_at(3, "C_pend", 0, 3, 4'b0001, 4'h0, 0);
        tick(4);
        expect_at(15, "C_hi_last", 1, 0, 4'b0001, 4'h0, 1);
        expect_at(16, "C_gap",     0, 0, 4'b0001, 4'h0, 1);
        expect_at(17, "C_re",      1, 0, 4'b0001, 4'h0, 1);
        tick(19);
        INTA = 1'b1; expect_at(1, "C_svc", 0, 0, 4'h0, 4'h0, 1);
        tick(1);
        INTA = 1'b0; eret = 1'b1; expect_at(1, "C_idle", 0, 0, 4'h0, 4'h0, 0);
        tick(1);
        eret = 1'b0; irq_in = 4'h0;
        tick(3);

        // Overflow, with set winning over a simultaneous clear
        irq_in = 4'b0001;
        tick(2);
        irq_in = 4'h0;
        tick(2);
        irq_in = 4'b0001; irq_q.push_back(3'd0);
        expect_at(0, "D_int", 1, 0, 4'b0001, 4'h0, 1);
        tick(2);
        ovf_clr = 1'b1; expect_at(1, "D_ovf_win", 1, 0, 4'b0001, 4'b0001, 1);
        tick(1);
        INTA = 1'b1; expect_at(1, "D_clr", 0, 0, 4'h0, 4'h0, 1);
        tick(1);
        ovf_clr = 1'b0; INTA = 1'b0; eret = 1'b1; expect_at(1, "D_idle", 0, 0, 4'h0, 4'h0, 0);
        tick(1);
        eret = 1'b0; irq_in = 4'h0;
        tick(3);

        // New event on the same cycle as its acknowledge keeps pending, no overflow
        irq_in = 4'b0010; irq_q.push_back(3'd1); irq_q.push_back(3'd1);
        tick(2);
        irq_in = 4'h0;
        tick(2);
        irq_in = 4'b0010;
        tick(2);
        INTA = 1'b1; expect_at(1, "E_setwin", 0, 1, 4'b0010, 4'h0, 1);
        tick(1);
        INTA = 1'b0; eret = 1'b1;
        expect_at(1, "E_idle",  0, 1, 4'b0010, 4'h0, 0);
        expect_at(2, "E_rereq", 1, 1, 4'b0010, 4'h0, 1);
        tick(1);
        eret = 1'b0;
        tick(1);
        INTA = 1'b1; expect_at(1, "E_ack", 0, 1, 4'h0, 4'h0, 1);
        tick(1);
        INTA = 1'b0; eret = 1'b1; expect_at(1, "E_done", 0, 1, 4'h0, 4'h0, 0);
        tick(1);
        eret = 1'b0; irq_in = 4'h0;
        tick(3);

        // Masked source pends silently; unmask requests; re-mask withdraws
        mask = 4'b1110; irq_in = 4'b0001;
        expect_at(3, "F_pend",  0, 1, 4'b0001, 4'h0, 0);
        expect_at(5, "F_noint", 0, 1, 4'b0001, 4'h0, 0);
        tick(6);
        mask = 4'hF; irq_q.push_back(3'd0);
        expect_at(1, "F_int", 1, 0, 4'b0001, 4'h0, 1);
        tick(1);
        mask = 4'b1110; expect_at(1, "F_wd", 0, 0, 4'b0001, 4'h0, 0);
        tick(1);
        mask = 4'hF; irq_q.push_back(3'd0);
        expect_at(1, "F_re", 1, 0, 4'b0001, 4'h0, 1);
        tick(1);
        INTA = 1'b1; expect_at(1, "F_ack", 0, 0, 4'h0, 4'h0, 1);
        tick(1);
        INTA = 1'b0; irq_in = 4'h0;
        tick(2);

        // Reset mid-service, irq held high through release
        irq_in = 4'b1000;
        expect_at(3, "G_pend", 0, 0, 4'b1000, 4'h0, 1);
        tick(4);
        #2 rst = 1'b0;
        expect_at(0, "G_async", 0, 0, 4'h0, 4'h0, 0);
        tick(2);
        rst = 1'b1;
        expect_at(8, "G_norq", 0, 0, 4'h0, 4'h0, 0);
        tick(8);
        irq_in = 4'h0;

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
        tick(2);
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            vectors++;
            fails++;
            $display("FAIL %s: never checked, required by cycle %0d", nm, e.cyc);
        end
        while (irq_q.size() > 0) begin
            exp_src = irq_q.pop_front();
            vectors++;
            fails++;
            $display("FAIL int_rise: missing INT rising edge, got none, want src_id=%0d", exp_src);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/int_req_ctrl.md
INT_REQ_CTRL -- requirements
Module: int_req_ctrl

Interface
REQ-001 Parameter N_SRC, default 4: number of interrupt sources, 2..8.
REQ-002 Parameter TIMEOUT, default 16: cycles INT stays high without INTA before a re-trigger, 2..255.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low; state SHALL clear while rst=0.
REQ-005 Port irq_in  input  N_SRC  asynchronous device requests; a rising edge signals an event.
REQ-006 Port mask  input  N_SRC  1 = source may request; 0 = source may pend but never requests.
REQ-007 Port INTA  input  1  one-cycle CPU acknowledge of the current request.
REQ-008 Port eret  input  1  one-cycle CPU return-from-interrupt.
REQ-009 Port ovf_clr  input  1  clears the overflow flags.
REQ-010 Port INT  output  1  interrupt request to the CPU, registered; the CPU samples its rising edge.
REQ-011 Port src_id  output  3  index of the source being requested or serviced; only [clog2(N_SRC)-1:0] used, upper bits 0.
REQ-012 Port pending  output  N_SRC  pending event flags.
REQ-013 Port overflow  output  N_SRC  sticky flags: event lost because that source was already pending.
REQ-014 Port busy  output  1  1 in states ASSERT, GAP and SERVICE.

Function
REQ-015 irq_in SHALL pass through a 2-flop synchronizer per bit; a 0->1 transition of the synchronized bit is an event, giving 3-cycle latency from pin to pending.
REQ-016 An event SHALL set pending[i]; an event with pending[i] already 1 and not cleared that cycle SHALL set overflow[i].
REQ-017 An event in the same cycle that clears pending[i] SHALL leave pending[i]=1 (set wins) and SHALL NOT set overflow.
REQ-018 Eligible set = pending & mask; the lowest eligible index SHALL have highest priority.
REQ-019 FSM states: IDLE, ASSERT, GAP, SERVICE; reset state IDLE.
REQ-020 IDLE: INT=0; if the eligible set is non-empty, latch src_id to the winner and go to ASSERT; INT rises the following cycle.
REQ-021 ASSERT: INT=1; src_id frozen; the retry counter increments each cycle, starting at 0 on entry.
REQ-022 ASSERT with INTA=1: clear pending[src_id], reset the counter, go to SERVICE.
REQ-023 ASSERT, no INTA, counter = TIMEOUT-1: go to GAP, so INT is high for exactly TIMEOUT cycles.
REQ-024 GAP: INT=0 for exactly one cycle, then return to ASSERT with the same src_id, producing a fresh rising edge; INTA during GAP SHALL be treated as in ASSERT.
REQ-025 If mask[src_id] drops in ASSERT or GAP, the request SHALL be withdrawn: return to IDLE with pending unchanged.
REQ-026 SERVICE: INT=0; src_id held; new events keep pending; no new request until eret=1, then go to IDLE.
REQ-027 INTA outside ASSERT/GAP and eret outside SERVICE SHALL be ignored.
REQ-028 When INTA and eret are both 1, only the event valid for the current state SHALL be taken.
REQ-029 ovf_clr=1 SHALL zero overflow; a simultaneous overflow set SHALL win.

Reset
REQ-030 While rst=0: INT=0, src_id=0, pending=0, overflow=0, busy=0, FSM=IDLE, counter=0, synchronizers=0.
REQ-031 Reset asserted mid-request or mid-service SHALL abort immediately, with no INT glitch high.
REQ-032 irq_in already high at reset release SHALL NOT create an event; a fresh rising edge is needed.

Verification
REQ-033 Single event: mask=4'hF, irq_in[2] rises -> pending=4'b0100 after 3 cycles, INT=1 next cycle with src_id=2; INTA -> pending=0, INT=0; eret -> busy=0.
REQ-034 Priority: irq_in[3] and irq_in[1] rise together -> src_id=1 serviced first; after eret, src_id=3 requested.
REQ-035 Timeout: no INTA -> INT high 16 cycles, low 1 cycle, high again with src_id unchanged; INTA on the 3rd cycle of the 2nd pulse -> SERVICE.
REQ-036 Overflow: two rising edges on irq_in[0] before INTA -> overflow=4'b0001; ovf_clr -> overflow=0.
REQ-037 Mask: mask=4'b1110, irq_in[0] rises -> pending[0]=1, INT stays 0; mask[0] set -> request with src_id=0.
REQ-038 Reset mid-SERVICE: rst=0 -> all outputs 0 asynchronously; irq_in held high through release -> no request.
